md_hazard_ctrl: RTL and testbench

Pipeline hazard and multiply/divide sequencing controller for the five-stage CPU. It compares D-stage source registers against in-flight writers in E and M using Tuse/Tnew. It tracks the multi-cycle HI/LO unit with an internal busy FSM. From these it drives the D-register hold, the PC enable, the E-register bubble and the D/E-stage forwarding selects.

---
 rtl/md_hazard_ctrl_pkg.sv | 30 +++
 rtl/md_hazard_ctrl_md_busy_fsm.sv | 51 +++++
 rtl/md_hazard_ctrl.sv | 82 ++++++++
 tb/tb_md_hazard_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/md_hazard_ctrl_pkg.sv
// Shared encodings for the hazard/multiply-divide controller: forwarding selects,
// the unused-Tuse marker, MD sequencer states and the forwarding-select helper.
package md_hazard_ctrl_pkg;

   localparam logic [1:0] FWD_RF    = 2'd0;
   localparam logic [1:0] FWD_M     = 2'd1;
   localparam logic [1:0] FWD_W     = 2'd2;
   localparam logic [1:0] TUSE_NONE = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      DIV  = 2'd2
   } md_state_t;

   // M wins over W; an M producer still computing (tnew != 0) cannot forward yet.
   function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                          input logic [4:0] m_wreg,
                                          input logic [1:0] m_tnew,
                                          input logic [4:0] w_wreg);
      logic [1:0] sel;
      sel = FWD_RF;
      if (src != 5'd0) begin
         if (src == m_wreg && m_tnew == 2'd0) sel = FWD_M;
         else if (src == w_wreg)              sel = FWD_W;
      end
      return sel;
   endfunction

endpackage

// File: rtl/md_hazard_ctrl_md_busy_fsm.sv
// HI/LO unit occupancy tracker: after a start it reports busy for exactly
// MULT_CYC or DIV_CYC cycles; starts seen while busy are ignored.
module md_busy_fsm
   import md_hazard_ctrl_pkg::*;
#(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic md_start,
   input  logic md_div,
   output logic md_busy
);

   md_state_t  state, state_nxt;
   logic [3:0] cnt, cnt_nxt;

   // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // NOTE: defaults first so no path through the case leaves a latch behind.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
         IDLE: begin
            if (md_start) begin
               state_nxt = md_div ? DIV : MULT;
               cnt_nxt   = md_div ? 4'(DIV_CYC - 1) : 4'(MULT_CYC - 1);
            end
         end
         MULT, DIV: begin
            if (cnt == 4'd0) state_nxt = IDLE;
            else             cnt_nxt   = cnt - 4'd1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign md_busy = (state != IDLE);

endmodule

// File: rtl/md_hazard_ctrl.sv
// Pipeline hazard controller: D-stage stall from Tuse/Tnew and HI/LO occupancy,
// plus D/E forwarding selects. Define HAZARD_FWD_EN to enable forwarding.
module md_hazard_ctrl
   import md_hazard_ctrl_pkg::*;
#(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] d_rs,
   input  logic [4:0] d_rt,
   input  logic [1:0] d_tuse_rs,
   input  logic [1:0] d_tuse_rt,
   input  logic       d_is_md,
   input  logic [4:0] e_rs,
   input  logic [4:0] e_rt,
   input  logic [4:0] e_wreg,
   input  logic [4:0] m_wreg,
   input  logic [4:0] w_wreg,
   input  logic [1:0] e_tnew,
   input  logic [1:0] m_tnew,
   input  logic       e_md_start,
   input  logic       e_md_div,
   output logic       stall,
   output logic       d_hold,
   output logic       pc_en,
   output logic       e_clr,
   output logic       md_busy,
   output logic [1:0] fwd_d_rs,
   output logic [1:0] fwd_d_rt,
   output logic [1:0] fwd_e_rs,
   output logic [1:0] fwd_e_rt
);

   logic stall_rs, stall_rt, stall_md;

   md_busy_fsm #(
      .MULT_CYC (MULT_CYC),
      .DIV_CYC  (DIV_CYC)
   ) u_md_busy_fsm (
      .clk      (clk),
      .reset    (reset),
      .md_start (e_md_start),
      .md_div   (e_md_div),
      .md_busy  (md_busy)
   );

`ifdef HAZARD_FWD_EN
   // Tuse of TUSE_NONE can never be exceeded by a 2-bit Tnew, so unused sources never stall.
   assign stall_rs = (d_rs != 5'd0) &&
                     ((d_rs == e_wreg && e_tnew > d_tuse_rs) ||
                      (d_rs == m_wreg && m_tnew > d_tuse_rs));
   assign stall_rt = (d_rt != 5'd0) &&
                     ((d_rt == e_wreg && e_tnew > d_tuse_rt) ||
                      (d_rt == m_wreg && m_tnew > d_tuse_rt));

   assign fwd_d_rs = fwd_sel(d_rs, m_wreg, m_tnew, w_wreg);
   assign fwd_d_rt = fwd_sel(d_rt, m_wreg, m_tnew, w_wreg);
   assign fwd_e_rs = fwd_sel(e_rs, m_wreg, m_tnew, w_wreg);
   assign fwd_e_rt = fwd_sel(e_rt, m_wreg, m_tnew, w_wreg);
`else
   // Without bypass paths any pending E/M writer blocks the read; W is covered by regfile write-through.
   assign stall_rs = (d_rs != 5'd0) && (d_rs == e_wreg || d_rs == m_wreg);
   assign stall_rt = (d_rt != 5'd0) && (d_rt == e_wreg || d_rt == m_wreg);

   assign fwd_d_rs = FWD_RF;
   assign fwd_d_rt = FWD_RF;
   assign fwd_e_rs = FWD_RF;
   assign fwd_e_rt = FWD_RF;

   logic unused_nofwd;
   assign unused_nofwd = ^{d_tuse_rs, d_tuse_rt, e_rs, e_rt, w_wreg, e_tnew, m_tnew};
`endif

   assign stall_md = d_is_md && (md_busy || e_md_start);
   assign stall    = stall_rs || stall_rt || stall_md;
   assign d_hold   = stall;
   assign pc_en    = !stall;
   assign e_clr    = stall;

endmodule

// File: tb/tb_md_hazard_ctrl.sv
// Self-checking bench for md_hazard_ctrl: table-driven hazard/forwarding vectors
// through a scoreboard queue, plus hand-written MD busy sequences.
module tb_md_hazard_ctrl;
   import md_hazard_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] d_rs, d_rt, e_rs, e_rt, e_wreg, m_wreg, w_wreg;
   logic [1:0] d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
   logic       d_is_md, e_md_start, e_md_div;
   logic       stall, d_hold, pc_en, e_clr, md_busy;
   logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;

   int n_vec = 0;
   int n_err = 0;

   md_hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
      .clk(clk), .reset(reset),
      .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
      .d_is_md(d_is_md), .e_rs(e_rs), .e_rt(e_rt),
      .e_wreg(e_wreg), .m_wreg(m_wreg), .w_wreg(w_wreg),
      .e_tnew(e_tnew), .m_tnew(m_tnew),
      .e_md_start(e_md_start), .e_md_div(e_md_div),
      .stall(stall), .d_hold(d_hold), .pc_en(pc_en), .e_clr(e_clr), .md_busy(md_busy),
      .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt), .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] d_rs, d_rt;
      logic [1:0] tu_rs, tu_rt;
      logic [4:0] e_rs, e_rt, e_wreg, m_wreg, w_wreg;
      logic [1:0] e_tnew, m_tnew;
      logic       st_fwd, st_nofwd;
      logic [1:0] fdrs, fdrt, fers, fert;
   } vec_t;

   typedef struct {
      logic       stall;
      logic [1:0] fdrs, fdrt, fers, fert;
   } exp_t;

   vec_t vecs[12];
   exp_t sb[$];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      d_rs = 0; d_rt = 0; d_tuse_rs = TUSE_NONE; d_tuse_rt = TUSE_NONE;
      d_is_md = 0; e_rs = 0; e_rt = 0; e_wreg = 0; m_wreg = 0; w_wreg = 0;
      e_tnew = 0; m_tnew = 0; e_md_start = 0; e_md_div = 0;
   endtask

   task automatic check_stall_group(input string name, input logic exp_stall);
      check({name, "_stall"},  8'(stall),  8'(exp_stall));
      check({name, "_d_hold"}, 8'(d_hold), 8'(exp_stall));
      check({name, "_pc_en"},  8'(pc_en),  8'(!exp_stall));
      check({name, "_e_clr"},  8'(e_clr),  8'(exp_stall));
   endtask

   initial begin
      //            d_rs d_rt tu_rs tu_rt e_rs e_rt e_w m_w w_w etn mtn stF stN fdrs fdrt fers fert
      vecs[0]  = '{0,  0,  3, 3, 0, 0, 0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0}; // idle
      vecs[1]  = '{8,  0,  0, 3, 0, 0, 8,  0,  0,  2, 0, 1, 1, 0, 0, 0, 0}; // load-use via E
      vecs[2]  = '{8,  0,  0, 3, 0, 0, 0,  8,  0,  0, 1, 1, 1, 0, 0, 0, 0}; // load-use via M
      vecs[3]  = '{0,  9,  3, 1, 0, 0, 0,  9,  9,  0, 0, 0, 1, 0, 1, 0, 0}; // M beats W
      vecs[4]  = '{0,  0,  0, 0, 0, 0, 0,  0,  0,  2, 0, 0, 0, 0, 0, 0, 0}; // register 0
      vecs[5]  = '{5,  6,  1, 1, 0, 0, 6,  0,  5,  1, 0, 0, 1, 2, 0, 0, 0}; // W fwd, tnew==tuse
      vecs[6]  = '{0,  0,  3, 3, 7, 3, 0,  7,  3,  0, 0, 0, 0, 0, 0, 1, 2}; // E-stage M and W
      vecs[7]  = '{0,  0,  3, 3, 7, 0, 0,  7,  7,  0, 1, 0, 0, 0, 0, 2, 0}; // M not ready -> W
      vecs[8]  = '{4,  0,  2, 3, 0, 0, 4,  0,  0,  2, 0, 0, 1, 0, 0, 0, 0}; // tnew == tuse
      vecs[9]  = '{0,  12, 3, 3, 0, 0, 12, 0,  0,  3, 0, 0, 1, 0, 0, 0, 0}; // unused source
      vecs[10] = '{0,  10, 3, 0, 0, 0, 0,  10, 0,  0, 1, 1, 1, 0, 0, 0, 0}; // rt via M
      vecs[11] = '{0,  0,  3, 3, 0, 0, 0,  0,  0,  0, 0, 0, 0, 0, 0, 0, 0}; // e_rs 0 vs m 0

      clear_inputs();
      reset = 1'b0;
      #12;
      check("rst_busy", 8'(md_busy), 8'd0);
      check_stall_group("rst", 1'b0);
      check("rst_fwd", {fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt}, 8'd0);
      reset = 1'b1;
      step();

      // Table vectors through the scoreboard.
      for (int i = 0; i < 12; i++) begin
         exp_t e;
         d_rs = vecs[i].d_rs; d_rt = vecs[i].d_rt;
         d_tuse_rs = vecs[i].tu_rs; d_tuse_rt = vecs[i].tu_rt;
         e_rs = vecs[i].e_rs; e_rt = vecs[i].e_rt;
         e_wreg = vecs[i].e_wreg; m_wreg = vecs[i].m_wreg; w_wreg = vecs[i].w_wreg;
         e_tnew = vecs[i].e_tnew; m_tnew = vecs[i].m_tnew;
`ifdef HAZARD_FWD_EN
         e = '{vecs[i].st_fwd, vecs[i].fdrs, vecs[i].fdrt, vecs[i].fers, vecs[i].fert};
`else
         e = '{vecs[i].st_nofwd, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
         sb.push_back(e);
         @(negedge clk);
         if (sb.size() == 0) begin
            check("sb_empty", 8'd1, 8'd0);
         end else begin
            e = sb.pop_front();
            check_stall_group($sformatf("v%0d", i), e.stall);
            check($sformatf("v%0d_fwd_d_rs", i), 8'(fwd_d_rs), 8'(e.fdrs));
            check($sformatf("v%0d_fwd_d_rt", i), 8'(fwd_d_rt), 8'(e.fdrt));
            check($sformatf("v%0d_fwd_e_rs", i), 8'(fwd_e_rs), 8'(e.fers));
            check($sformatf("v%0d_fwd_e_rt", i), 8'(fwd_e_rt), 8'(e.fert));
         end
         step();
      end
      clear_inputs();

      // Div: MD instr held in D stalls from the start cycle through all 10 busy cycles.
      step();
      d_is_md = 1; e_md_start = 1; e_md_div = 1;
      #1;
      check("div_start_busy", 8'(md_busy), 8'd0);
      check_stall_group("div_start", 1'b1);
      step();
      e_md_start = 0; e_md_div = 0;
      for (int i = 0; i < 10; i++) begin
         check($sformatf("div_busy%0d", i + 1), 8'(md_busy), 8'd1);
         check($sformatf("div_stall%0d", i + 1), 8'(stall), 8'd1);
         step();
      end
      check("div_done_busy", 8'(md_busy), 8'd0);
      check_stall_group("div_done", 1'b0);
      d_is_md = 0;

      // Mult with a second start at busy cycle 3: no reload, still 5 cycles total.
      step();
      e_md_start = 1; e_md_div = 0;
      step();
      e_md_start = 0;
      for (int i = 1; i <= 5; i++) begin
         if (i == 3) begin
            e_md_start = 1; e_md_div = 1;
         end
         check($sformatf("mul_rst_busy%0d", i), 8'(md_busy), 8'd1);
         step();
         e_md_start = 0; e_md_div = 0;
      end
      check("mul_rst_done", 8'(md_busy), 8'd0);

      // Async reset in the middle of a div.
      step();
      e_md_start = 1; e_md_div = 1; d_is_md = 1;
      step();
      e_md_start = 0; e_md_div = 0;
      step(); step();
      check("mid_div_busy", 8'(md_busy), 8'd1);
      reset = 1'b0;
      #1;
      check("arst_busy", 8'(md_busy), 8'd0);
      check("arst_pc_en", 8'(pc_en), 8'd1);
      #2;
      reset = 1'b1;
      step();
      check("post_rst_busy", 8'(md_busy), 8'd0);
      d_is_md = 0;
      e_md_start = 1; e_md_div = 0;
      step();
      e_md_start = 0;
      for (int i = 1; i <= 5; i++) begin
         check($sformatf("mul_busy%0d", i), 8'(md_busy), 8'd1);
         step();
      end
      check("mul_done", 8'(md_busy), 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
